// File: rtl/wbk_arb.sv
// Write-back arbiter: many result channels share one register-file write port.
// Define WBK_ARB_RR_EN for round-robin arbitration; otherwise lowest-index writer wins.
module wbk_arb #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int DEST_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        CH_VALID_SI,
  input  logic [NUM_CH-1:0]        CH_WB_SI,
  input  logic [NUM_CH*DEST_W-1:0] CH_DEST_SI,
  input  logic [NUM_CH*DATA_W-1:0] CH_DATA_SI,
  output logic [NUM_CH-1:0]        CH_READY_SW,
  output logic                     WB_SW,
  output logic [DEST_W-1:0]        DEST_SW,
  output logic [DATA_W-1:0]        DATA_SW,
  output logic [NUM_CH-1:0]        GRANT_SW
);

  logic [NUM_CH-1:0] writer;
  logic [NUM_CH-1:0] non_writer;
  logic [NUM_CH-1:0] grant_oh;

  logic              wb_q, wb_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0] grant_q, grant_d;

  // Destination 0 is never written, so such entries retire like stores.
  always_comb begin
    writer     = '0;
    non_writer = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      writer[i]     = CH_VALID_SI[i] & CH_WB_SI[i] &
                      (CH_DEST_SI[i*DEST_W +: DEST_W] != '0);
      non_writer[i] = CH_VALID_SI[i] & ~writer[i];
    end
  end

`ifdef WBK_ARB_RR_EN
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Winner is the writer at the smallest upward distance from the pointer.
  always_comb begin : rr_select
    int dist;
    int best_dist;
    grant_oh  = '0;
    dist      = 0;
    best_dist = NUM_CH;
    for (int i = 0; i < NUM_CH; i++) begin
      dist = i - int'(ptr_q);
      if (dist < 0) dist = dist + NUM_CH;
      if (writer[i] && (dist < best_dist)) begin
        best_dist   = dist;
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) ptr_d = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (writer[i]) begin
        grant_oh    = '0;
        grant_oh[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    wb_d    = |grant_oh;
    grant_d = grant_oh;
    dest_d  = dest_q;
    data_d  = data_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i]) begin
        dest_d = CH_DEST_SI[i*DEST_W +: DEST_W];
        data_d = CH_DATA_SI[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q    <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      wb_q    <= wb_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  // Ready is forced low during reset so nothing is consumed while the outputs are cleared.
  assign CH_READY_SW = reset ? '0 : (non_writer | grant_oh);
  assign WB_SW       = wb_q;
  assign DEST_SW     = dest_q;
  assign DATA_SW     = data_q;
  assign GRANT_SW    = grant_q;

endmodule

// File: tb/tb_wbk_arb.sv
// Self-checking bench for wbk_arb against a queue-based arbitration model.
// Adapts its expectations to the WBK_ARB_RR_EN build option.
module tb_wbk_arb;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]  v_s = '0;
  logic [N-1:0]  w_s = '0;
  logic [TW-1:0] d_s [N];
  logic [DW-1:0] x_s [N];
  logic [N*TW-1:0] dest_bus;
  logic [N*DW-1:0] data_bus;

  logic [N-1:0]  rdy;
  logic          wb;
  logic [TW-1:0] dst;
  logic [DW-1:0] dat;
  logic [N-1:0]  gnt;

  int errors = 0;
  int checks = 0;

  int            m_ptr;
  logic          m_wb;
  logic [TW-1:0] m_dest;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_gnt;
  logic [N-1:0]  exp_rdy;
  int            exp_g;

  always #5 clk = ~clk;

  always_comb begin
    dest_bus = '0;
    data_bus = '0;
    for (int i = 0; i < N; i++) begin
      dest_bus[i*TW +: TW] = d_s[i];
      data_bus[i*DW +: DW] = x_s[i];
    end
  end

  wbk_arb #(.NUM_CH(N), .DATA_W(DW), .DEST_W(TW)) dut (
    .clk(clk), .reset(reset),
    .CH_VALID_SI(v_s), .CH_WB_SI(w_s),
    .CH_DEST_SI(dest_bus), .CH_DATA_SI(data_bus),
    .CH_READY_SW(rdy), .WB_SW(wb), .DEST_SW(dst), .DATA_SW(dat), .GRANT_SW(gnt)
  );

  // Model: list writers in index order, then pick the first at/after the pointer
  // (round-robin) or simply the first (fixed priority).
  function automatic void model_eval();
    int writers[$];
    exp_g   = -1;
    exp_rdy = '0;
    for (int i = 0; i < N; i++)
      if (v_s[i] && w_s[i] && d_s[i] != '0) writers.push_back(i);
    if (writers.size() > 0) begin
      exp_g = writers[0];
`ifdef WBK_ARB_RR_EN
      for (int j = writers.size() - 1; j >= 0; j--)
        if (writers[j] >= m_ptr) exp_g = writers[j];
`endif
    end
    for (int i = 0; i < N; i++)
      if (v_s[i] && (i == exp_g || !(w_s[i] && d_s[i] != '0))) exp_rdy[i] = 1'b1;
  endfunction

  function automatic void model_clock();
    if (exp_g >= 0) begin
      m_wb  = 1'b1;
      m_gnt = N'(1) << exp_g;
      for (int i = 0; i < N; i++)
        if (i == exp_g) begin
          m_dest = d_s[i];
          m_data = x_s[i];
        end
      m_ptr = (exp_g + 1) % N;
    end else begin
      m_wb  = 1'b0;
      m_gnt = '0;
    end
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_wb = 1'b0; m_dest = '0; m_data = '0; m_gnt = '0;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w,
                       input logic [TW-1:0] d0, input logic [TW-1:0] d1, input logic [TW-1:0] d2,
                       input logic [DW-1:0] x0, input logic [DW-1:0] x1, input logic [DW-1:0] x2);
    @(negedge clk);
    v_s = v; w_s = w;
    d_s[0] = d0; d_s[1] = d1; d_s[2] = d2;
    x_s[0] = x0; x_s[1] = x1; x_s[2] = x2;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    v_s = 3'b111; w_s = 3'b111;
    for (int i = 0; i < N; i++) begin d_s[i] = TW'(i + 1); x_s[i] = DW'(i + 100); end
    model_reset();
    #2;
    checks++;
    if (rdy !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", rdy); end
    @(posedge clk); #1;
    checks++;
    if (wb !== 1'b0 || gnt !== 3'b000 || dst !== '0 || dat !== '0) begin
      errors++; $display("FAIL reset_outputs got wb=%b gnt=%b dst=%0d dat=%h exp all zero", wb, gnt, dst, dat);
    end
    @(negedge clk);
    reset = 1'b0;
    v_s = '0; w_s = '0;
    #1;
    model_eval();
  endtask

  task automatic test_all_writers();
    logic [N-1:0]  seq_g [4];
    logic [TW-1:0] seq_d [4];
`ifdef WBK_ARB_RR_EN
    seq_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    seq_d = '{6'd1, 6'd2, 6'd3, 6'd1};
`else
    seq_g = '{3'b001, 3'b001, 3'b001, 3'b001};
    seq_d = '{6'd1, 6'd1, 6'd1, 6'd1};
`endif
    drive(3'b111, 3'b111, 6'd1, 6'd2, 6'd3, 32'hA0, 32'hA1, 32'hA2);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rdy !== seq_g[c] || rdy !== exp_rdy) begin
        errors++; $display("FAIL all_writers_ready[%0d] got=%b exp=%b", c, rdy, seq_g[c]);
      end
      tick();
      checks++;
      if (wb !== 1'b1 || gnt !== seq_g[c] || dst !== seq_d[c]) begin
        errors++; $display("FAIL all_writers_out[%0d] got wb=%b gnt=%b dst=%0d exp wb=1 gnt=%b dst=%0d",
                           c, wb, gnt, dst, seq_g[c], seq_d[c]);
      end
    end
  endtask

  task automatic test_single_writer();
    drive(3'b010, 3'b010, 6'd0, 6'd5, 6'd0, 32'h0, 32'hDEADBEEF, 32'h0);
    checks++;
    if (rdy !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", rdy); end
    tick();
    checks++;
    if (wb !== 1'b1 || dst !== 6'd5 || dat !== 32'hDEADBEEF || gnt !== 3'b010) begin
      errors++; $display("FAIL single_out got wb=%b dst=%0d dat=%h gnt=%b exp 1/5/deadbeef/010", wb, dst, dat, gnt);
    end
    drive(3'b000, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
    tick();
    checks++;
    if (wb !== 1'b0 || gnt !== 3'b000 || dst !== 6'd5 || dat !== 32'hDEADBEEF) begin
      errors++; $display("FAIL idle_hold got wb=%b gnt=%b dst=%0d dat=%h exp 0/000/5/deadbeef", wb, gnt, dst, dat);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] seq_g [3];
`ifdef WBK_ARB_RR_EN
    seq_g = '{3'b100, 3'b001, 3'b010};
`else
    seq_g = '{3'b001, 3'b001, 3'b001};
`endif
    drive(3'b101, 3'b101, 6'd10, 6'd0, 6'd12, 32'hC0, 32'h0, 32'hC2);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== seq_g[c] || gnt !== m_gnt) begin
        errors++; $display("FAIL wrap_grant[%0d] got=%b exp=%b", c, gnt, seq_g[c]);
      end
    end
    drive(3'b111, 3'b111, 6'd10, 6'd11, 6'd12, 32'hC0, 32'hC1, 32'hC2);
    tick();
    checks++;
    if (gnt !== seq_g[2]) begin errors++; $display("FAIL wrap_ptr_grant got=%b exp=%b", gnt, seq_g[2]); end
  endtask

  task automatic test_mixed();
    drive(3'b111, 3'b110, 6'd4, 6'd0, 6'd7, 32'h55, 32'h66, 32'h12);
    checks++;
    if (rdy !== 3'b111) begin errors++; $display("FAIL mixed_ready got=%b exp=111", rdy); end
    tick();
    checks++;
    if (wb !== 1'b1 || dst !== 6'd7 || dat !== 32'h12 || gnt !== 3'b100) begin
      errors++; $display("FAIL mixed_out got wb=%b dst=%0d dat=%h gnt=%b exp 1/7/12/100", wb, dst, dat, gnt);
    end
  endtask

  task automatic test_invalid_ignored();
    drive(3'b000, 3'b111, 6'd21, 6'd22, 6'd23, 32'hF0, 32'hF1, 32'hF2);
    checks++;
    if (rdy !== 3'b000) begin errors++; $display("FAIL invalid_ready got=%b exp=000", rdy); end
    tick();
    checks++;
    if (wb !== 1'b0 || gnt !== 3'b000 || dst !== 6'd7 || dat !== 32'h12) begin
      errors++; $display("FAIL invalid_out got wb=%b gnt=%b dst=%0d dat=%h exp 0/000/7/12", wb, gnt, dst, dat);
    end
  endtask

  task automatic test_reset_midstream();
    drive(3'b001, 3'b001, 6'd9, 6'd0, 6'd0, 32'hA5, 32'h0, 32'h0);
    tick();
    checks++;
    if (wb !== 1'b1 || dst !== 6'd9) begin
      errors++; $display("FAIL midreset_pre got wb=%b dst=%0d exp 1/9", wb, dst);
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (wb !== 1'b0 || gnt !== '0 || dst !== '0 || dat !== '0 || rdy !== '0) begin
      errors++; $display("FAIL midreset_clear got wb=%b gnt=%b dst=%0d dat=%h rdy=%b exp all zero", wb, gnt, dst, dat, rdy);
    end
    @(negedge clk);
    reset = 1'b0;
    v_s = 3'b111; w_s = 3'b111;
    d_s[0] = 6'd1; d_s[1] = 6'd2; d_s[2] = 6'd3;
    #1;
    model_eval();
    tick();
    checks++;
    if (gnt !== 3'b001 || dst !== 6'd1) begin
      errors++; $display("FAIL post_reset_grant got gnt=%b dst=%0d exp 001/1", gnt, dst);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] renew;
    int wait_cnt [N];
    renew = '1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (renew[i]) begin
          v_s[i] = ($urandom_range(0, 3) != 0);
          w_s[i] = ($urandom_range(0, 4) != 0);
          d_s[i] = TW'($urandom_range(0, 5));
          x_s[i] = $urandom;
        end
      end
      #1;
      model_eval();
      checks++;
      if (rdy !== exp_rdy) begin errors++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, rdy, exp_rdy); end
      for (int i = 0; i < N; i++) begin
        if (v_s[i] && w_s[i] && d_s[i] != '0 && !rdy[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
`ifdef WBK_ARB_RR_EN
        checks++;
        if (wait_cnt[i] >= N) begin errors++; $display("FAIL rand_fair ch%0d waited=%0d limit=%0d", i, wait_cnt[i], N - 1); end
`endif
      end
      renew = ~v_s | exp_rdy;
      tick();
      checks++;
      if (wb !== m_wb || gnt !== m_gnt || dst !== m_dest || dat !== m_data) begin
        errors++; $display("FAIL rand_out[%0d] got wb=%b gnt=%b dst=%0d dat=%h exp wb=%b gnt=%b dst=%0d dat=%h",
                           c, wb, gnt, dst, dat, m_wb, m_gnt, m_dest, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_writers();
    test_single_writer();
    test_wrap();
    test_mixed();
    test_invalid_ignored();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
